// File: rtl/jt12_i2s_tx.sv
// jt12_i2s_tx: Philips I2S transmitter for the YM2612 mixer output, with a one-deep sample buffer
//   clk        : system clock (same as the FM core)
//   rst_n      : asynchronous active-low reset
//   snd_left   : signed 16-bit left sample
//   snd_right  : signed 16-bit right sample
//   snd_sample : sample strobe, new sample on its rising edge
//   i2s_bclk   : bit clock, clk / BCLK_DIV
//   i2s_lrclk  : word select, 0 = left slot, 1 = right slot
//   i2s_data   : serial data, MSB first, one BCLK after the LRCLK change
//   overrun    : one-cycle pulse when an unsent pending sample is replaced
//   underrun   : one-cycle pulse when a frame starts without a new sample
module jt12_i2s_tx #(
    parameter int BCLK_DIV = 4,
    parameter int SLOT_W   = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] snd_left,
    input  logic [15:0] snd_right,
    input  logic        snd_sample,
    output logic        i2s_bclk,
    output logic        i2s_lrclk,
    output logic        i2s_data,
    output logic        overrun,
    output logic        underrun
);
    localparam int DW = $clog2(BCLK_DIV);
    localparam int PW = $clog2(2 * SLOT_W);
    localparam logic [DW-1:0] DIV_MAX  = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [PW-1:0] POS_MAX  = PW'(2 * SLOT_W - 1);
    localparam logic [PW-1:0] POS_SLOT = PW'(SLOT_W);

    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          smp_q;
    logic [15:0]   pend_l_q, pend_l_d, pend_r_q, pend_r_d;
    logic          pend_vld_q, pend_vld_d;
    logic [15:0]   frm_l_q, frm_l_d, frm_r_q, frm_r_d;
    logic          bclk_q, lrclk_q, data_q, ovr_q, unr_q;
    logic          tick, load, cap, slot_d, data_d;
    logic [PW-1:0] bit_d, k_d;
    logic [15:0]   word_d;

    always_comb begin
        tick       = div_q == DIV_MAX;
        div_d      = tick ? '0 : div_q + DW'(1);
        pos_d      = !tick ? pos_q : (pos_q == POS_MAX) ? '0 : pos_q + PW'(1);
        load       = tick && pos_q == '0;
        cap        = snd_sample && !smp_q;
        frm_l_d    = (load && pend_vld_q) ? pend_l_q : frm_l_q;
        frm_r_d    = (load && pend_vld_q) ? pend_r_q : frm_r_q;
        pend_l_d   = cap ? snd_left : pend_l_q;
        pend_r_d   = cap ? snd_right : pend_r_q;
        // a capture in the load cycle refills the buffer the load just emptied
        pend_vld_d = cap || (pend_vld_q && !load);
        // one-bit I2S delay: position p carries bit (p-1), so p=0 ends the previous right slot
        bit_d      = (pos_d == '0) ? POS_MAX : pos_d - PW'(1);
        slot_d     = bit_d >= POS_SLOT;
        k_d        = slot_d ? bit_d - POS_SLOT : bit_d;
        word_d     = slot_d ? frm_r_d : frm_l_d;
        data_d     = (k_d[PW-1:4] == '0) && word_d[~k_d[3:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q      <= '0;
            pos_q      <= '0;
            smp_q      <= 1'b0;
            pend_l_q   <= '0;
            pend_r_q   <= '0;
            pend_vld_q <= 1'b0;
            frm_l_q    <= '0;
            frm_r_q    <= '0;
            bclk_q     <= 1'b0;
            lrclk_q    <= 1'b0;
            data_q     <= 1'b0;
            ovr_q      <= 1'b0;
            unr_q      <= 1'b0;
        end else begin
            div_q      <= div_d;
            pos_q      <= pos_d;
            smp_q      <= snd_sample;
            pend_l_q   <= pend_l_d;
            pend_r_q   <= pend_r_d;
            pend_vld_q <= pend_vld_d;
            frm_l_q    <= frm_l_d;
            frm_r_q    <= frm_r_d;
            bclk_q     <= div_d >= DIV_HALF;
            lrclk_q    <= pos_d >= POS_SLOT;
            data_q     <= data_d;
            ovr_q      <= cap && pend_vld_q && !load;
            unr_q      <= load && !pend_vld_q;
        end
    end

    assign i2s_bclk  = bclk_q;
    assign i2s_lrclk = lrclk_q;
    assign i2s_data  = data_q;
    assign overrun   = ovr_q;
    assign underrun  = unr_q;
endmodule
